// File: rtl/vpu_pipe.sv
// vpu_pipe: per-lane vector post-processing (bias add -> ReLU -> requantise), fixed 3-stage pipeline.
// Latency: exactly 3 cycles for every mode, one beat per lane per cycle.
// Backpressure: none; every accepted beat emerges 3 cycles later. Dropped beats never enter the pipe.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   vpu_mode[2:0]       [0] bias add, [1] ReLU, [2] requantise (sampled with the data)
//   vpu_shift           requantise right-shift amount (sampled with the data)
//   vpu_sys_*_in        per-lane psum E and its valid
//   vpu_bias_*_in       per-lane bias C and its valid
//   vpu_err_clr         clears sticky alignment errors and the saturation counter
//   vpu_data_out        per-lane signed result, zero when not valid
//   vpu_valid_out       per-lane result valid
//   vpu_sat_out         per-lane "this beat was clipped"
//   vpu_align_err       sticky per-lane sys/bias valid mismatch mask
//   vpu_sat_cnt         saturating count of clipped lane-beats
module vpu_pipe #(
  parameter int VPU_WIDTH      = 16,
  parameter int DATA_WIDTH_IN  = 32,
  parameter int DATA_WIDTH_OUT = 8,
  parameter int SHIFT_WIDTH    = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [2:0]                               vpu_mode,
  input  logic [SHIFT_WIDTH-1:0]                   vpu_shift,
  input  logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0]  vpu_sys_data_in,
  input  logic [VPU_WIDTH-1:0]                     vpu_sys_valid_in,
  input  logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0]  vpu_bias_data_in,
  input  logic [VPU_WIDTH-1:0]                     vpu_bias_valid_in,
  input  logic                                     vpu_err_clr,
  output logic [VPU_WIDTH-1:0][DATA_WIDTH_IN-1:0]  vpu_data_out,
  output logic [VPU_WIDTH-1:0]                     vpu_valid_out,
  output logic [VPU_WIDTH-1:0]                     vpu_sat_out,
  output logic [VPU_WIDTH-1:0]                     vpu_align_err,
  output logic [CNT_WIDTH-1:0]                     vpu_sat_cnt
);

  localparam int W = DATA_WIDTH_IN;

  localparam logic [W-1:0]        IN_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        IN_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W:0]   Q_MAX  = (W+1)'((1 << (DATA_WIDTH_OUT-1)) - 1);
  localparam logic signed [W:0]   Q_MIN  = ~Q_MAX;  // -Q_MAX-1

  // Saturating E + C. Returns {sat, data}.
  function automatic logic [W:0] f_sat_add(input logic [W-1:0] e, input logic [W-1:0] c);
    logic [W:0] s;
    s = {e[W-1], e} + {c[W-1], c};
    // Top two bits disagree only when the true sum left the W-bit range.
    if (s[W] != s[W-1]) return {1'b1, (s[W] ? IN_MIN : IN_MAX)};
    return {1'b0, s[W-1:0]};
  endfunction

  // Round-half-up arithmetic shift, then clip to the narrow output range. Returns {sat, data}.
  function automatic logic [W:0] f_requant(input logic [W-1:0] v, input logic [SHIFT_WIDTH-1:0] sh);
    logic signed [W:0] x;
    logic signed [W:0] rnd;
    logic signed [W:0] r;
    x   = {v[W-1], v};
    rnd = '0;
    if (sh != '0) rnd = (W+1)'(1) << (sh - SHIFT_WIDTH'(1));
    // One extra bit keeps x + rnd from wrapping even for the largest positive input.
    r = (x + rnd) >>> sh;
    if (r > Q_MAX) return {1'b1, Q_MAX[W-1:0]};
    if (r < Q_MIN) return {1'b1, Q_MIN[W-1:0]};
    return {1'b0, r[W-1:0]};
  endfunction

  // Stage registers. Mode/shift travel with the data so in-flight beats keep their own settings.
  logic [VPU_WIDTH-1:0]          r_s1_vld, r_s2_vld, r_s3_vld;
  logic [VPU_WIDTH-1:0][W-1:0]   r_s1_dat, r_s2_dat, r_s3_dat;
  logic [VPU_WIDTH-1:0]          r_s1_sat, r_s2_sat, r_s3_sat;
  logic [2:1]                    r_s1_mode;
  logic                          r_s2_rq;
  logic [SHIFT_WIDTH-1:0]        r_s1_shift, r_s2_shift;
  logic [VPU_WIDTH-1:0]          r_align_err;
  logic [CNT_WIDTH-1:0]          r_sat_cnt;

  logic [VPU_WIDTH-1:0]          w_s1_vld, w_s1_sat, w_s2_sat, w_s3_sat;
  logic [VPU_WIDTH-1:0][W-1:0]   w_s1_dat, w_s2_dat, w_s3_dat;
  logic [VPU_WIDTH-1:0][W:0]     w_rq;
  logic [VPU_WIDTH-1:0]          w_align_set;
  logic [CNT_WIDTH-1:0]          w_sat_inc, w_cnt_base, w_cnt_nxt;
  logic [CNT_WIDTH:0]            w_cnt_sum;

  // S1: valid qualification and saturating bias add.
  assign w_s1_vld    = vpu_mode[0] ? (vpu_sys_valid_in & vpu_bias_valid_in) : vpu_sys_valid_in;
  assign w_align_set = vpu_mode[0] ? (vpu_sys_valid_in ^ vpu_bias_valid_in) : '0;

  always_comb begin
    w_s1_dat = '0;
    w_s1_sat = '0;
    for (int j = 0; j < VPU_WIDTH; j++) begin
      if (w_s1_vld[j]) begin
        if (vpu_mode[0]) {w_s1_sat[j], w_s1_dat[j]} = f_sat_add(vpu_sys_data_in[j], vpu_bias_data_in[j]);
        else             w_s1_dat[j] = vpu_sys_data_in[j];
      end
    end
  end

  // S2: optional ReLU.
  always_comb begin
    w_s2_dat = '0;
    w_s2_sat = '0;
    for (int j = 0; j < VPU_WIDTH; j++) begin
      if (r_s1_vld[j]) begin
        w_s2_dat[j] = (r_s1_mode[1] && r_s1_dat[j][W-1]) ? '0 : r_s1_dat[j];
        w_s2_sat[j] = r_s1_sat[j];
      end
    end
  end

  // S3: optional requantise.
  always_comb begin
    w_rq     = '0;
    w_s3_dat = '0;
    w_s3_sat = '0;
    for (int j = 0; j < VPU_WIDTH; j++) begin
      w_rq[j] = f_requant(r_s2_dat[j], r_s2_shift);
      if (r_s2_vld[j]) begin
        if (r_s2_rq) begin
          w_s3_dat[j] = w_rq[j][W-1:0];
          w_s3_sat[j] = r_s2_sat[j] | w_rq[j][W];
        end else begin
          w_s3_dat[j] = r_s2_dat[j];
          w_s3_sat[j] = r_s2_sat[j];
        end
      end
    end
  end

  // Saturation event counter: adds the clipped beats currently on the output.
  always_comb begin
    w_sat_inc = '0;
    for (int j = 0; j < VPU_WIDTH; j++) begin
      w_sat_inc = w_sat_inc + CNT_WIDTH'(r_s3_vld[j] & r_s3_sat[j]);
    end
  end

  // Clear takes effect by dropping the old value; same-cycle increments still land.
  assign w_cnt_base = vpu_err_clr ? '0 : r_sat_cnt;
  assign w_cnt_sum  = {1'b0, w_cnt_base} + {1'b0, w_sat_inc};
  assign w_cnt_nxt  = w_cnt_sum[CNT_WIDTH] ? '1 : w_cnt_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld    <= '0;
      r_s1_dat    <= '0;
      r_s1_sat    <= '0;
      r_s1_mode   <= '0;
      r_s1_shift  <= '0;
      r_s2_vld    <= '0;
      r_s2_dat    <= '0;
      r_s2_sat    <= '0;
      r_s2_rq     <= 1'b0;
      r_s2_shift  <= '0;
      r_s3_vld    <= '0;
      r_s3_dat    <= '0;
      r_s3_sat    <= '0;
      r_align_err <= '0;
      r_sat_cnt   <= '0;
    end else begin
      r_s1_vld    <= w_s1_vld;
      r_s1_dat    <= w_s1_dat;
      r_s1_sat    <= w_s1_sat;
      r_s1_mode   <= vpu_mode[2:1];
      r_s1_shift  <= vpu_shift;
      r_s2_vld    <= r_s1_vld;
      r_s2_dat    <= w_s2_dat;
      r_s2_sat    <= w_s2_sat;
      r_s2_rq     <= r_s1_mode[2];
      r_s2_shift  <= r_s1_shift;
      r_s3_vld    <= r_s2_vld;
      r_s3_dat    <= w_s3_dat;
      r_s3_sat    <= w_s3_sat;
      r_align_err <= (vpu_err_clr ? '0 : r_align_err) | w_align_set;
      r_sat_cnt   <= w_cnt_nxt;
    end
  end

  assign vpu_data_out  = r_s3_dat;
  assign vpu_valid_out = r_s3_vld;
  assign vpu_sat_out   = r_s3_sat;
  assign vpu_align_err = r_align_err;
  assign vpu_sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_vpu_pipe.sv
// tb_vpu_pipe: scoreboard bench for vpu_pipe with directed corner beats and randomized streams.
// Expected results come from an arithmetic model of the post-processing rules, queued per lane.
// A negedge monitor pops and compares whenever a lane presents a valid result.
module tb_vpu_pipe;
  localparam int V = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        vpu_mode;
  logic [4:0]        vpu_shift;
  logic [V-1:0][31:0] sys_d, bias_d;
  logic [V-1:0]      sys_v, bias_v;
  logic              err_clr;
  logic [V-1:0][31:0] data_out;
  logic [V-1:0]      valid_out, sat_out, align_err;
  logic [15:0]       sat_cnt;

  vpu_pipe dut (
    .clk(clk), .rst(rst), .vpu_mode(vpu_mode), .vpu_shift(vpu_shift),
    .vpu_sys_data_in(sys_d), .vpu_sys_valid_in(sys_v),
    .vpu_bias_data_in(bias_d), .vpu_bias_valid_in(bias_v),
    .vpu_err_clr(err_clr),
    .vpu_data_out(data_out), .vpu_valid_out(valid_out), .vpu_sat_out(sat_out),
    .vpu_align_err(align_err), .vpu_sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int dat; bit sat; int cyc; } exp_t;
  exp_t q [V][$];

  int n_chk = 0, n_err = 0;
  bit mon_en = 1'b0;
  int exp_satcnt = 0;
  logic [V-1:0] exp_align = '0;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  task automatic chk(input string name, input int lane, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s lane=%0d cyc=%0d: got %0d expected %0d", name, lane, cyc, act, exp);
    end
  endtask

  // Reference model of one lane-beat.
  task automatic model(input logic [2:0] m, input int sh, input int e, input int c,
                       output int r, output bit s);
    longint v, rr;
    s = 1'b0;
    if (m[0]) begin
      v = longint'(e) + longint'(c);
      if (v > MAXV) begin v = MAXV; s = 1'b1; end
      else if (v < MINV) begin v = MINV; s = 1'b1; end
    end else begin
      v = e;
    end
    if (m[1] && v < 0) v = 0;
    if (m[2]) begin
      rr = v + ((sh > 0) ? (64'sd1 << (sh - 1)) : 64'sd0);
      rr = rr >>> sh;
      if (rr > 127) begin rr = 127; s = 1'b1; end
      else if (rr < -128) begin rr = -128; s = 1'b1; end
      v = rr;
    end
    r = int'(v);
  endtask

  // Push expectations for the inputs currently driven, then advance one cycle.
  task automatic step();
    logic [V-1:0] vld, mis;
    int r;
    bit s;
    vld = vpu_mode[0] ? (sys_v & bias_v) : sys_v;
    mis = '0;
    for (int j = 0; j < V; j++)
      if (vpu_mode[0] && (sys_v[j] != bias_v[j])) mis[j] = 1'b1;
    if (err_clr) exp_satcnt = 0;
    exp_align = (err_clr ? '0 : exp_align) | mis;
    for (int j = 0; j < V; j++) begin
      if (vld[j]) begin
        model(vpu_mode, int'(vpu_shift), int'(sys_d[j]), int'(bias_d[j]), r, s);
        q[j].push_back('{r, s, cyc + 3});
        if (s && exp_satcnt < 65535) exp_satcnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sys_v = '0; bias_v = '0; vpu_mode = 3'b000; err_clr = 1'b0;
    repeat (n) step();
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 4000)) - 32'd2000;
      1: return $urandom;
      2: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FF00 + 32'($urandom_range(0, 255))
                                            : 32'h8000_0000 + 32'($urandom_range(0, 255));
      default: return 32'($urandom_range(0, 600)) - 32'd300;
    endcase
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      for (int j = 0; j < V; j++) begin
        if (valid_out[j]) begin
          if (q[j].size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_valid lane=%0d cyc=%0d: got valid with data %0d expected no beat",
                     j, cyc, $signed(data_out[j]));
          end else begin
            e = q[j].pop_front();
            chk("data", j, longint'($signed(data_out[j])), longint'(e.dat));
            chk("sat", j, longint'(sat_out[j]), longint'(e.sat));
            chk("latency_cycle", j, longint'(cyc), longint'(e.cyc));
          end
        end else begin
          chk("idle_data", j, longint'(data_out[j]), 0);
          chk("idle_sat", j, longint'(sat_out[j]), 0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; err_clr = 1'b0; vpu_mode = '0; vpu_shift = '0;
    sys_d = '0; bias_d = '0; sys_v = '0; bias_v = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", -1, longint'(valid_out), 0);
    chk("rst_sat", -1, longint'(sat_out), 0);
    chk("rst_align", -1, longint'(align_err), 0);
    chk("rst_satcnt", -1, longint'(sat_cnt), 0);
    for (int j = 0; j < V; j++) chk("rst_data", j, longint'(data_out[j]), 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Simple bias add on lane 0 only.
    vpu_mode = 3'b001; sys_v = 16'h0001; bias_v = 16'h0001;
    sys_d[0] = 32'd100; bias_d[0] = -32'sd30;
    step();
    // Positive and negative saturation.
    sys_v = 16'h0003; bias_v = 16'h0003;
    sys_d[0] = 32'h7FFF_FFF0; bias_d[0] = 32'h20;
    sys_d[1] = 32'h8000_0000; bias_d[1] = 32'hFFFF_FFFF;
    step();
    // ReLU clamp, then requantise cases including both clip directions.
    vpu_mode = 3'b011; sys_v = 16'h0001; bias_v = 16'h0001;
    sys_d[0] = -32'sd50; bias_d[0] = 32'd10;
    step();
    vpu_mode = 3'b111; vpu_shift = 5'd3; sys_v = 16'h000F; bias_v = 16'h000F;
    sys_d[0] = 32'd1000;  bias_d[0] = 32'd0;
    sys_d[1] = 32'd1100;  bias_d[1] = 32'd0;
    sys_d[2] = -32'sd1100; bias_d[2] = 32'd0;
    sys_d[3] = 32'd12;    bias_d[3] = 32'd0;
    step();
    vpu_mode = 3'b101; sys_d[2] = -32'sd1100;
    step();
    vpu_shift = 5'd0; sys_d[0] = 32'd127; sys_d[1] = 32'd128; sys_d[2] = -32'sd129;
    step();
    vpu_shift = 5'd31; sys_d[0] = 32'h7FFF_FFFF; bias_d[0] = 32'd0;
    sys_d[1] = 32'h4000_0000; bias_d[1] = 32'd0;
    step();
    // Requant only, bias ignored.
    vpu_mode = 3'b100; vpu_shift = 5'd4; bias_v = '0; sys_d[0] = -32'sd24;
    step();
    idle(5);
    chk("satcnt_directed", -1, longint'(sat_cnt), longint'(exp_satcnt));
    chk("align_none", -1, longint'(align_err), longint'(exp_align));

    // Misaligned lane 3, sticky, then clear.
    vpu_mode = 3'b001; sys_v = 16'h0009; bias_v = 16'h0001;
    sys_d[0] = 32'd5; bias_d[0] = 32'd6; sys_d[3] = 32'd77;
    step();
    idle(4);
    chk("align_lane3", -1, longint'(align_err), longint'(exp_align));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("align_cleared", -1, longint'(align_err), longint'(exp_align));
    chk("satcnt_cleared", -1, longint'(sat_cnt), longint'(exp_satcnt));
    // Clear and a new mismatch in the same cycle: the set wins.
    vpu_mode = 3'b001; sys_v = 16'h0000; bias_v = 16'h0020; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    idle(1);
    chk("align_set_wins", -1, longint'(align_err), longint'(exp_align));

    // Back-to-back mode toggling on a full stream.
    for (int i = 0; i < 24; i++) begin
      vpu_mode = (i % 2 == 1) ? 3'b111 : 3'b001;
      vpu_shift = 5'($urandom_range(0, 8));
      sys_v = '1; bias_v = '1;
      for (int j = 0; j < V; j++) begin
        sys_d[j] = 32'($urandom_range(0, 4000)) - 32'd2000;
        bias_d[j] = 32'($urandom_range(0, 400)) - 32'd200;
      end
      step();
    end
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      vpu_mode = 3'($urandom_range(0, 7));
      vpu_shift = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 10));
      sys_v = 16'($urandom);
      bias_v = sys_v;
      if ($urandom_range(0, 7) == 0) bias_v[$urandom_range(0, V-1)] ^= 1'b1;
      for (int j = 0; j < V; j++) begin
        sys_d[j] = rnd_val();
        bias_d[j] = rnd_val();
      end
      step();
    end
    idle(5);
    chk("align_random", -1, longint'(align_err), longint'(exp_align));
    chk("satcnt_random", -1, longint'(sat_cnt), longint'(exp_satcnt));

    // Drive the counter into its ceiling.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    vpu_mode = 3'b001; sys_v = '1; bias_v = '1;
    for (int j = 0; j < V; j++) begin sys_d[j] = 32'h7FFF_FFFF; bias_d[j] = 32'd1; end
    repeat (4200) step();
    idle(5);
    chk("satcnt_ceiling", -1, longint'(sat_cnt), longint'(exp_satcnt));

    // Reset with beats in flight, one of them misaligned.
    vpu_mode = 3'b001; sys_v = '1; bias_v = 16'hFFFB;
    for (int j = 0; j < V; j++) begin sys_d[j] = 32'(j * 11); bias_d[j] = 32'd3; end
    repeat (3) step();
    rst = 1'b1;
    for (int j = 0; j < V; j++) q[j].delete();
    exp_align = '0; exp_satcnt = 0;
    sys_v = '0; bias_v = '0; vpu_mode = '0;
    #1;
    chk("midrst_valid", -1, longint'(valid_out), 0);
    chk("midrst_sat", -1, longint'(sat_out), 0);
    chk("midrst_align", -1, longint'(align_err), 0);
    chk("midrst_satcnt", -1, longint'(sat_cnt), 0);
    for (int j = 0; j < V; j++) chk("midrst_data", j, longint'(data_out[j]), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(6);
    vpu_mode = 3'b001; sys_v = 16'h8000; bias_v = 16'h8000;
    sys_d[15] = -32'sd7; bias_d[15] = 32'd2;
    step();
    idle(5);
    chk("post_rst_align", -1, longint'(align_err), longint'(exp_align));

    for (int j = 0; j < V; j++) chk("missing_beats", j, longint'(q[j].size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
